// File: rtl/sram_req_adapter.sv
// rtl/sram_req_adapter.sv - valid/ready request adapter for a 1-cycle-latency single-port SRAM
//
// Purpose: issues handshaked requests to the sram request port, captures read
// data one cycle after each access and returns one in-order response per
// request through a small credit-protected FIFO.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o request handshake
//   req_we_i, req_addr_i, req_wdata_i, req_be_i   request payload
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_rdata_o, rsp_write_o                      response payload (rdata zero for writes)
//   sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o  to sram request port
//   sram_rdata_i                                  sram read data, one cycle after sram_req_o
module sram_req_adapter #(
  parameter  int DATA_WIDTH = 64,
  parameter  int N_WORDS    = 1024,
  parameter  int RSP_DEPTH  = 3,
  localparam int ADDR_WIDTH = $clog2(N_WORDS),
  localparam int N_BYTES    = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [N_BYTES-1:0]    req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_write_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [N_BYTES-1:0]    sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

  logic                  inflight_q;
  logic                  inflight_we_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [DATA_WIDTH:0]   fifo_mem [RSP_DEPTH];

  logic                  push;
  logic                  pop;
  logic [CNT_W:0]        used;
  logic [DATA_WIDTH-1:0] push_data;

  // Pointers wrap explicitly so RSP_DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Every accepted request owns a FIFO slot from acceptance until it is
  // popped, so counting the in-flight access as used makes the push below
  // overflow-free. Only registered state feeds ready.
  assign used        = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};
  assign req_ready_o = used < DEPTH_C;

  // Credits read as free while in reset; keep the macro idle regardless.
  assign sram_req_o   = req_valid_i & req_ready_o & ~rst_i;
  assign sram_we_o    = req_we_i & sram_req_o;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  assign push      = inflight_q;
  assign push_data = inflight_we_q ? '0 : sram_rdata_i;

  assign rsp_valid_o = (cnt_q != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;

  // Gate the head with valid so outputs read as zero while empty or in reset.
  assign rsp_rdata_o = rsp_valid_o ? fifo_mem[rd_ptr_q][DATA_WIDTH-1:0] : '0;
  assign rsp_write_o = rsp_valid_o & fifo_mem[rd_ptr_q][DATA_WIDTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q    <= 1'b0;
      inflight_we_q <= 1'b0;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      inflight_q    <= sram_req_o;
      inflight_we_q <= sram_we_o;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; entries are only observable once counted.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= {inflight_we_q, push_data};
  end

endmodule

// File: tb/tb_sram_req_adapter.sv
// tb/tb_sram_req_adapter.sv - self-checking bench for sram_req_adapter
module tb_sram_req_adapter;

  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int NB    = 8;
  localparam int DEPTH = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [NB-1:0] req_be_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_write_o;
  logic          sram_req_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [NB-1:0] sram_be_o;
  logic [DW-1:0] sram_rdata_i = '0;

  sram_req_adapter #(.DATA_WIDTH(DW), .N_WORDS(1024), .RSP_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_write_o(rsp_write_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Environment: the sram macro, 1-cycle read latency, byte-enabled writes.
  // Write cycles return junk so the adapter's zeroing is exercised.
  logic [DW-1:0] sram_mem [1024];
  initial forever begin
    @(posedge clk_i);
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < NB; b++)
          if (sram_be_o[b]) sram_mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
        sram_rdata_i <= {$urandom, $urandom};
      end else begin
        sram_rdata_i <= sram_mem[sram_addr_o];
      end
    end
  end

  // Reference model: memory contents plus a queue of outstanding responses,
  // each stamped with its acceptance cycle.
  typedef struct {
    int            cyc;
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [1024];
  int            cyc = 0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i]  = '0;
      model_mem[i] = '0;
    end
  end

  initial forever begin
    logic exp_ready, exp_valid, exp_req;
    exp_t e;
    @(negedge clk_i);
    cyc++;
    if (rst_i) begin
      exp_q.delete();
      check("rst_req_ready", 64'(req_ready_o), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_rsp_rdata", rsp_rdata_o, 64'd0);
      check("rst_rsp_write", 64'(rsp_write_o), 64'd0);
      check("rst_sram_req", 64'(sram_req_o), 64'd0);
      check("rst_sram_we", 64'(sram_we_o), 64'd0);
    end else begin
      exp_ready = exp_q.size() < DEPTH;
      exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
      exp_req   = req_valid_i & exp_ready;
      check("m_req_ready", 64'(req_ready_o), 64'(exp_ready));
      check("m_rsp_valid", 64'(rsp_valid_o), 64'(exp_valid));
      check("m_sram_req", 64'(sram_req_o), 64'(exp_req));
      check("m_sram_we", 64'(sram_we_o), 64'(exp_req & req_we_i));
      check("m_sram_addr", 64'(sram_addr_o), 64'(req_addr_i));
      check("m_sram_wdata", sram_wdata_o, req_wdata_i);
      check("m_sram_be", 64'(sram_be_o), 64'(req_be_i));
      if (exp_valid) begin
        check("m_rsp_write", 64'(rsp_write_o), 64'(exp_q[0].we));
        check("m_rsp_rdata", rsp_rdata_o, exp_q[0].data);
        if (rsp_ready_i) void'(exp_q.pop_front());
      end
      if (exp_req) begin
        e.cyc  = cyc;
        e.we   = req_we_i;
        e.data = req_we_i ? '0 : model_mem[req_addr_i];
        exp_q.push_back(e);
        if (req_we_i)
          for (int b = 0; b < NB; b++)
            if (req_be_i[b]) model_mem[req_addr_i][b*8 +: 8] = req_wdata_i[b*8 +: 8];
      end
    end
  end

  // One request cycle; assumes credit is available.
  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NB-1:0] be);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wdata_i = d; req_be_i = be;
    @(negedge clk_i);
    check("acc_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  // Called right after do_req: nothing at n+1, the response at n+2.
  task automatic expect_rsp(input string name, input logic w, input logic [DW-1:0] d);
    @(negedge clk_i);
    check({name, "_early"}, 64'(rsp_valid_o), 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    check({name, "_valid"}, 64'(rsp_valid_o), 64'd1);
    check({name, "_write"}, 64'(rsp_write_o), 64'(w));
    check({name, "_rdata"}, rsp_rdata_o, d);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int acc;
    int n;
    rst_i = 1'b1; req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_be_i = '0; rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("reset_ready", 64'(req_ready_o), 64'd1);
    check("reset_sram_req", 64'(sram_req_o), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; req_valid_i = 1'b0;
    @(posedge clk_i); #1;

    // Full write then read back.
    do_req(1'b1, 10'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    expect_rsp("wr5", 1'b1, 64'd0);
    do_req(1'b0, 10'd5, '0, '0);
    expect_rsp("rd5", 1'b0, 64'hDEADBEEF_CAFEF00D);

    // Partial write merges into the old word.
    do_req(1'b1, 10'd9, 64'hAAAAAAAA_BBBBBBBB, 8'hFF);
    expect_rsp("wr9a", 1'b1, 64'd0);
    do_req(1'b1, 10'd9, 64'h11111111_22222222, 8'h0F);
    expect_rsp("wr9b", 1'b1, 64'd0);
    do_req(1'b0, 10'd9, '0, '0);
    expect_rsp("rd9", 1'b0, 64'hAAAAAAAA_22222222);

    // Preload addr 0..15 with value = addr.
    for (int i = 0; i < 16; i++) do_req(1'b1, AW'(i), DW'(i), 8'hFF);
    repeat (4) @(posedge clk_i); #1;

    // Back-to-back reads at full throughput.
    for (int c = 0; c < 18; c++) begin
      req_valid_i = (c < 16); req_we_i = 1'b0; req_addr_i = AW'(c);
      @(negedge clk_i);
      if (c < 16) check("b2b_ready", 64'(req_ready_o), 64'd1);
      if (c >= 2) begin
        check("b2b_rsp_valid", 64'(rsp_valid_o), 64'd1);
        check("b2b_rdata", rsp_rdata_o, 64'(c - 2));
      end
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk_i); #1;

    // Backpressure: exactly DEPTH accepts, then a stable head.
    rsp_ready_i = 1'b0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = AW'(c);
      @(negedge clk_i);
      if (req_ready_o) acc++;
      @(posedge clk_i); #1;
    end
    check("bp_accepted", 64'(acc), 64'd3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      check("bp_ready_low", 64'(req_ready_o), 64'd0);
      check("bp_head_valid", 64'(rsp_valid_o), 64'd1);
      check("bp_head_rdata", rsp_rdata_o, 64'd0);
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("bp_drain_valid", 64'(rsp_valid_o), 64'd1);
      check("bp_drain_rdata", rsp_rdata_o, 64'(k));
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    check("bp_drain_done", 64'(rsp_valid_o), 64'd0);
    @(posedge clk_i); #1;

    // Reset with two buffered and one in flight.
    rsp_ready_i = 1'b0; n = 0;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 10'd20;
    do begin
      @(negedge clk_i);
      n++;
    end while (req_ready_o && n < 10);
    check("rst_setup_full", 64'(req_ready_o), 64'd0);
    #1 rst_i = 1'b1;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("midrst_sram_req", 64'(sram_req_o), 64'd0);
    repeat (2) @(posedge clk_i); #1;
    rst_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("postrst_no_stale", 64'(rsp_valid_o), 64'd0);
    @(posedge clk_i); #1;
    do_req(1'b0, 10'd7, '0, '0);
    expect_rsp("postrst_rd7", 1'b0, 64'd7);

    // Randomised mixed traffic against the model.
    acc = 0; n = 0;
    while (acc < 1000 && n < 20000) begin
      req_valid_i = ($urandom_range(0, 9) < 7);
      req_we_i    = 1'($urandom_range(0, 1));
      req_addr_i  = AW'($urandom_range(0, 31));
      req_wdata_i = {$urandom, $urandom};
      req_be_i    = NB'($urandom);
      rsp_ready_i = ($urandom_range(0, 9) < 6);
      @(negedge clk_i);
      if (req_valid_i && req_ready_o) acc++;
      @(posedge clk_i); #1;
      n++;
    end
    check("rand_accepted", 64'(acc), 64'd1000);
    req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    repeat (8) @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rand_all_returned", 64'(exp_q.size()), 64'd0);
    check("rand_final_empty", 64'(rsp_valid_o), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
